// File: rtl/exe_r_type_md_pkg.sv
// ----------------------------------------------------------------------------
// exe_r_type_md_pkg : shared decode codes and state encoding for exe_r_type_md
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package exe_r_type_md_pkg;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_MULH    = 3'b001;
  localparam logic [2:0] F3_MULHSU  = 3'b010;
  localparam logic [2:0] F3_MULHU   = 3'b011;
  localparam logic [2:0] F3_DIV     = 3'b100;
  localparam logic [2:0] F3_DIVU    = 3'b101;
  localparam logic [2:0] F3_REM     = 3'b110;
  localparam logic [2:0] F3_REMU    = 3'b111;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic ZERO          = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/exe_div_iter.sv
// ----------------------------------------------------------------------------
// exe_div_iter : restoring unsigned divider, one quotient bit per cycle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module exe_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff;
  logic            ge;

  // The dividend shifts out of quot as quotient bits shift in.
  assign trial = {rem, quot[XLEN-1]};
  assign ge    = trial >= {1'b0, dvs};
  assign diff  = trial[XLEN-1:0] - dvs;

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      cnt  <= '0;
      quot <= '0;
      rem  <= '0;
      dvs  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      cnt  <= CW'(XLEN);
      quot <= dividend;
      rem  <= '0;
      dvs  <= divisor;
      busy <= 1'b1;
    end else if (busy) begin
      quot <= {quot[XLEN-2:0], ge};
      rem  <= ge ? diff : trial[XLEN-1:0];
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

  assign done      = busy && (cnt == CW'(1));
  assign quotient  = quot;
  assign remainder = rem;

endmodule

`default_nettype wire

// File: rtl/exe_r_type_md.sv
// ----------------------------------------------------------------------------
// exe_r_type_md : RV32I R-type + M-extension execute unit with valid/ready
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module exe_r_type_md
  import exe_r_type_md_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit DIV_FAST_SPECIAL = 1'b1
) (
  input  logic            clk_in,
  input  logic            reset_in,
  input  logic            flush_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [31:0]     inst_in,
  input  logic [XLEN-1:0] op1_in,
  input  logic [XLEN-1:0] op2_in,
  output logic            valid_out,
  output logic [XLEN-1:0] reg_wdata_out,
  output logic            reg_we_out
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, next;

  logic [2:0]        f3;
  logic [6:0]        f7;
  logic              accept, is_base, is_alt, is_md, is_mul, is_div, alu_legal;
  logic              s1, s2, div_signed, want_rem;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   alu_res;
  logic [2*XLEN-1:0] ax, bx, prod;
  logic              neg1, neg2, by_zero, ovf, div_fast;
  logic [XLEN-1:0]   mag1, mag2, div_q, div_r, q_fix, r_fix, div_res;
  logic              div_busy, div_done, unused_bits;

  logic [2*XLEN-1:0] mul_prod;
  logic              mul_hi;
  logic              d_rem, d_negq, d_negr, d_zero, d_ovf;
  logic [XLEN-1:0]   d_op1;

  assign f3        = inst_in[14:12];
  assign f7        = inst_in[31:25];
  assign ready_out = (state == IDLE);
  assign accept    = valid_in && ready_out && !flush_in;
  assign shamt     = op2_in[SHW-1:0];

  assign is_base   = (f7 == F7_BASE);
  assign is_alt    = (f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA));
  assign is_md     = (f7 == F7_MULDIV);
  assign alu_legal = is_base || is_alt;

  always_comb begin
    alu_res = {XLEN{ZERO}};
    case (f3)
      F3_ADD_SUB: alu_res = is_alt ? (op1_in - op2_in) : (op1_in + op2_in);
      F3_SLL:     alu_res = op1_in << shamt;
      F3_SLT:     alu_res = {{(XLEN-1){1'b0}}, ($signed(op1_in) < $signed(op2_in))};
      F3_SLTU:    alu_res = {{(XLEN-1){1'b0}}, (op1_in < op2_in)};
      F3_XOR:     alu_res = op1_in ^ op2_in;
      F3_SRL_SRA: alu_res = is_alt ? XLEN'($signed(op1_in) >>> shamt) : (op1_in >> shamt);
      F3_OR:      alu_res = op1_in | op2_in;
      F3_AND:     alu_res = op1_in & op2_in;
      default:    alu_res = {XLEN{ZERO}};
    endcase
  end

  always_comb begin
    s1 = 1'b0; s2 = 1'b0; is_div = 1'b0; div_signed = 1'b0; want_rem = 1'b0;
    case (f3)
      F3_MUL:    begin s1 = 1'b1; s2 = 1'b1; end
      F3_MULH:   begin s1 = 1'b1; s2 = 1'b1; end
      F3_MULHSU: s1 = 1'b1;
      F3_MULHU:  s1 = 1'b0;
      F3_DIV:    begin is_div = 1'b1; div_signed = 1'b1; end
      F3_DIVU:   is_div = 1'b1;
      F3_REM:    begin is_div = 1'b1; div_signed = 1'b1; want_rem = 1'b1; end
      F3_REMU:   begin is_div = 1'b1; want_rem = 1'b1; end
      default:   is_div = 1'b0;
    endcase
    is_div = is_div && is_md;
    is_mul = is_md && !is_div;
  end

  // Sign-extend to 2*XLEN so a single unsigned multiply covers ss/su/uu.
  assign ax   = {{XLEN{s1 & op1_in[XLEN-1]}}, op1_in};
  assign bx   = {{XLEN{s2 & op2_in[XLEN-1]}}, op2_in};
  assign prod = ax * bx;

  assign neg1     = div_signed && op1_in[XLEN-1];
  assign neg2     = div_signed && op2_in[XLEN-1];
  assign mag1     = neg1 ? -op1_in : op1_in;
  assign mag2     = neg2 ? -op2_in : op2_in;
  assign by_zero  = (op2_in == {XLEN{ZERO}});
  assign ovf      = div_signed && (op1_in == MOST_NEG) && (op2_in == {XLEN{1'b1}});
  assign div_fast = DIV_FAST_SPECIAL && (by_zero || ovf);

  exe_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk_in),
    .rst       (reset_in),
    .abort     (flush_in),
    .start     (accept && is_div && !div_fast),
    .dividend  (mag1),
    .divisor   (mag2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign q_fix   = d_zero ? {XLEN{1'b1}} : d_ovf ? d_op1 : (d_negq ? -div_q : div_q);
  assign r_fix   = d_zero ? d_op1 : d_ovf ? {XLEN{ZERO}} : (d_negr ? -div_r : div_r);
  assign div_res = d_rem ? r_fix : q_fix;

  always_ff @(posedge clk_in) begin
    if (reset_in) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (accept) begin
              if (is_mul)      next = MUL;
              else if (is_div) next = div_fast ? DONE : DIV;
            end
      MUL:  next = IDLE;
      DIV:  if (div_done) next = DONE;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
    if (flush_in) next = IDLE;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      valid_out     <= 1'b0;
      reg_we_out    <= WRITE_DISABLE;
      reg_wdata_out <= {XLEN{ZERO}};
      mul_prod      <= '0;
      mul_hi        <= 1'b0;
      d_rem         <= 1'b0;
      d_negq        <= 1'b0;
      d_negr        <= 1'b0;
      d_zero        <= 1'b0;
      d_ovf         <= 1'b0;
      d_op1         <= {XLEN{ZERO}};
    end else begin
      valid_out  <= 1'b0;
      reg_we_out <= WRITE_DISABLE;
      if (accept && !is_md) begin
        valid_out     <= 1'b1;
        reg_we_out    <= alu_legal ? WRITE_ENABLE : WRITE_DISABLE;
        reg_wdata_out <= alu_legal ? alu_res : {XLEN{ZERO}};
      end else if (!flush_in && state == MUL) begin
        valid_out     <= 1'b1;
        reg_we_out    <= WRITE_ENABLE;
        reg_wdata_out <= mul_hi ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
      end else if (!flush_in && state == DONE) begin
        valid_out     <= 1'b1;
        reg_we_out    <= WRITE_ENABLE;
        reg_wdata_out <= div_res;
      end
      if (accept && is_mul) begin
        mul_prod <= prod;
        mul_hi   <= (f3 != F3_MUL);
      end
      if (accept && is_div) begin
        d_rem  <= want_rem;
        d_negq <= neg1 ^ neg2;
        d_negr <= neg1;
        d_zero <= by_zero;
        d_ovf  <= ovf;
        d_op1  <= op1_in;
      end
    end
  end

  assign unused_bits = &{1'b0, inst_in[24:15], inst_in[11:0], div_busy};

endmodule

`default_nettype wire

// File: tb/tb_exe_r_type_md.sv
// ----------------------------------------------------------------------------
// tb_exe_r_type_md : directed vector bench for exe_r_type_md (XLEN=32)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_exe_r_type_md;
  import exe_r_type_md_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_in, flush_in, valid_in;
  logic        ready_out, valid_out, reg_we_out;
  logic [31:0] inst_in, op1_in, op2_in, reg_wdata_out;

  int checks = 0;
  int fails  = 0;

  always #5 clk_in = ~clk_in;

  exe_r_type_md #(.XLEN(32), .DIV_FAST_SPECIAL(1'b1)) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .flush_in      (flush_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .inst_in       (inst_in),
    .op1_in        (op1_in),
    .op2_in        (op2_in),
    .valid_out     (valid_out),
    .reg_wdata_out (reg_wdata_out),
    .reg_we_out    (reg_we_out)
  );

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        we;
    int          lat;
    int          busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 10'b0, f3, 5'd1, 7'b0110011};
  endfunction

  task automatic add(input string n, input logic [6:0] f7, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] e,
                     input logic we, input int lat, input int busy);
    vec_t t;
    t.name = n; t.inst = mk(f7, f3); t.a = a; t.b = b; t.exp = e;
    t.we = we; t.lat = lat; t.busy = busy;
    vecs.push_back(t);
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_in);
    inst_in = inst; op1_in = a; op2_in = b; valid_in = 1'b1;
    @(posedge clk_in);
    #1 valid_in = 1'b0;
  endtask

  // Latency is counted in cycles after the accepting edge; 0 means timeout.
  task automatic wait_result(input int max, output int lat, output int busy);
    lat = 0; busy = 0;
    for (int n = 1; n <= max; n++) begin
      @(negedge clk_in);
      if (!ready_out) busy++;
      if (valid_out) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, busy, pulses;

    reset_in = 1'b1; flush_in = 1'b0; valid_in = 1'b0;
    inst_in = '0; op1_in = '0; op2_in = '0;
    repeat (3) @(posedge clk_in);
    #1 reset_in = 1'b0;
    @(negedge clk_in);
    check("reset ready", ready_out, 1);
    check("reset valid", valid_out, 0);
    check("reset we", reg_we_out, 0);
    check("reset wdata", reg_wdata_out, 0);

    add("ADD ovf", F7_BASE, F3_ADD_SUB, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 1, 0);
    add("SUB",     F7_ALT,  F3_ADD_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 1, 1, 0);
    add("SLL",     F7_BASE, F3_SLL, 32'h1, 32'h21, 32'h2, 1, 1, 0);
    add("SLT",     F7_BASE, F3_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 1, 1, 0);
    add("SLTU",    F7_BASE, F3_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 1, 1, 0);
    add("XOR",     F7_BASE, F3_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 1, 0);
    add("SRL",     F7_BASE, F3_SRL_SRA, 32'h80000010, 32'd4, 32'h08000001, 1, 1, 0);
    add("SRA",     F7_ALT,  F3_SRL_SRA, 32'h80000010, 32'd4, 32'hF8000001, 1, 1, 0);
    add("OR",      F7_BASE, F3_OR, 32'h0F0, 32'hF00, 32'hFF0, 1, 1, 0);
    add("AND",     F7_BASE, F3_AND, 32'hFF0, 32'h0F0, 32'h0F0, 1, 1, 0);
    add("MUL -1*-1", F7_MULDIV, F3_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 1, 2, 1);
    add("MUL",       F7_MULDIV, F3_MUL, 32'd12345, 32'd1000, 32'h00BC5EA8, 1, 2, 1);
    add("MULH",      F7_MULDIV, F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1, 2, 1);
    add("MULHU",     F7_MULDIV, F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 2, 1);
    add("MULHSU",    F7_MULDIV, F3_MULHSU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 1, 2, 1);
    add("DIV -7/2",  F7_MULDIV, F3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1, 34, 33);
    add("REM -7/2",  F7_MULDIV, F3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1, 34, 33);
    add("DIV 7/-2",  F7_MULDIV, F3_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 1, 34, 33);
    add("REM 7/-2",  F7_MULDIV, F3_REM, 32'd7, 32'hFFFFFFFE, 32'h1, 1, 34, 33);
    add("DIVU",      F7_MULDIV, F3_DIVU, 32'd100, 32'd7, 32'd14, 1, 34, 33);
    add("REMU",      F7_MULDIV, F3_REMU, 32'd100, 32'd7, 32'd2, 1, 34, 33);
    add("DIVU x/0",  F7_MULDIV, F3_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 2, 1);
    add("DIV x/0",   F7_MULDIV, F3_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 2, 1);
    add("REM 5/0",   F7_MULDIV, F3_REM, 32'd5, 32'd0, 32'd5, 1, 2, 1);
    add("REMU x/0",  F7_MULDIV, F3_REMU, 32'h80000000, 32'd0, 32'h80000000, 1, 2, 1);
    add("DIV ovf",   F7_MULDIV, F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 2, 1);
    add("REM ovf",   F7_MULDIV, F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 2, 1);
    add("ILL alt",   F7_ALT, F3_SLL, 32'h1234, 32'h1, 32'h0, 0, 1, 0);
    add("ILL f7",    7'b0000010, F3_ADD_SUB, 32'h1234, 32'h1, 32'h0, 0, 1, 0);

    foreach (vecs[i]) begin
      issue(vecs[i].inst, vecs[i].a, vecs[i].b);
      wait_result(40, lat, busy);
      check({vecs[i].name, " latency"}, lat, vecs[i].lat);
      check({vecs[i].name, " data"}, reg_wdata_out, vecs[i].exp);
      check({vecs[i].name, " we"}, reg_we_out, {31'b0, vecs[i].we});
      check({vecs[i].name, " busy cycles"}, busy, vecs[i].busy);
      @(negedge clk_in);
      check({vecs[i].name, " pulse width"}, valid_out, 0);
    end

    // Back-to-back single-cycle ops.
    @(negedge clk_in);
    inst_in = mk(F7_BASE, F3_ADD_SUB); op1_in = 32'd3; op2_in = 32'd4; valid_in = 1'b1;
    check("b2b ready0", ready_out, 1);
    @(negedge clk_in);
    check("b2b add valid", valid_out, 1);
    check("b2b add data", reg_wdata_out, 32'd7);
    check("b2b ready1", ready_out, 1);
    inst_in = mk(F7_ALT, F3_ADD_SUB); op1_in = 32'd10; op2_in = 32'd4;
    @(negedge clk_in);
    check("b2b sub valid", valid_out, 1);
    check("b2b sub data", reg_wdata_out, 32'd6);
    check("b2b ready2", ready_out, 1);
    valid_in = 1'b0;
    @(negedge clk_in);
    check("b2b idle valid", valid_out, 0);

    // Flush in IDLE blocks acceptance.
    @(negedge clk_in);
    inst_in = mk(F7_BASE, F3_ADD_SUB); op1_in = 32'd5; op2_in = 32'd5;
    valid_in = 1'b1; flush_in = 1'b1;
    @(negedge clk_in);
    valid_in = 1'b0; flush_in = 1'b0;
    check("idle flush valid", valid_out, 0);
    check("idle flush ready", ready_out, 1);

    // Flush during a divide at T+10, new ADD at T+11.
    issue(mk(F7_MULDIV, F3_DIVU), 32'd100, 32'd7);
    pulses = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_in);
      if (valid_out) pulses++;
    end
    @(negedge clk_in);
    if (valid_out) pulses++;
    flush_in = 1'b1;
    inst_in = mk(F7_BASE, F3_ADD_SUB); op1_in = 32'd1; op2_in = 32'd2; valid_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    check("flush ready T+11", ready_out, 1);
    check("flush valid T+11", valid_out, 0);
    @(negedge clk_in);
    valid_in = 1'b0;
    check("post-flush add valid", valid_out, 1);
    check("post-flush add data", reg_wdata_out, 32'd3);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if (valid_out) pulses++;
    end
    check("flushed div pulses", pulses, 0);

    // Reset while a multiply is in flight.
    issue(mk(F7_BASE, F3_ADD_SUB), 32'd1, 32'd2);
    wait_result(5, lat, busy);
    check("pre-reset add data", reg_wdata_out, 32'd3);
    issue(mk(F7_MULDIV, F3_MUL), 32'd3, 32'd5);
    reset_in = 1'b1;
    @(posedge clk_in);
    #1 reset_in = 1'b0;
    @(negedge clk_in);
    check("mid-mul reset valid", valid_out, 0);
    check("mid-mul reset we", reg_we_out, 0);
    check("mid-mul reset wdata", reg_wdata_out, 0);
    check("mid-mul reset ready", ready_out, 1);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      if (valid_out) pulses++;
    end
    check("mid-mul reset pulses", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exe_r_type_md.md
Name: exe_r_type_md

Overview:
Parametrised successor to the single-cycle R-type execute unit. Covers RV32I R-type ALU ops plus the M extension: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It sits in the EX stage and drives the register-file writeback pair. A valid/ready handshake stalls the pipeline for multi-cycle multiply and divide.

Parameters:
XLEN, 32, operand/result width (power of two, >=8); shift amount uses low log2(XLEN) bits of op2_in
DIV_FAST_SPECIAL, 1, 1 = divide-by-zero and signed overflow complete without iterating

Ports:
clk_in  in  1  clock, rising edge
reset_in  in  1  synchronous, active-high reset
flush_in  in  1  abort the in-flight op (branch/trap); takes priority over valid_in
valid_in  in  1  inst_in/op1_in/op2_in are valid this cycle
ready_out  out  1  unit can accept; equals (state==IDLE)
inst_in  in  32  instruction; funct3=[14:12], funct7=[31:25]
op1_in  in  XLEN  rs1 value
op2_in  in  XLEN  rs2 value
valid_out  out  1  one-cycle pulse: reg_wdata_out/reg_we_out valid
reg_wdata_out  out  XLEN  result
reg_we_out  out  1  write enable, qualified by valid_out

Behaviour:
- Reset (sync, reset_in=1 at clock edge):
  - state=IDLE; valid_out=0, reg_we_out=0, reg_wdata_out=0, ready_out=1.
  - Divider counter and operands cleared.
- Accept:
  - Occurs at edge T when valid_in && ready_out && !flush_in.
  - Operands and funct fields are latched; the unit does not re-sample inputs afterwards.
  - valid_in while busy is ignored; upstream holds it.
- Base ops (funct7 0000000/0100000):
  - Same semantics as before: ADD/SUB wrap mod 2^XLEN; SLT/SLTU yield 0/1; shifts use op2[log2(XLEN)-1:0].
  - SRA is true arithmetic (sign fill).
  - Latency 1: valid_out=1 in cycle T+1. State remains IDLE, so back-to-back issue is legal.
- MUL group (funct7 0000001, funct3 000-011):
  - IDLE->MUL at T; MUL->IDLE at T+1.
  - valid_out in T+2 (registered 2XLEN product).
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits with ss/su/uu signedness.
- DIV group (funct7 0000001, funct3 100-111):
  - Restoring divider, one quotient bit per cycle on magnitudes; signs fixed at the end.
  - IDLE->DIV at T; XLEN iterations; DIV->DONE; valid_out in T+XLEN+2, then IDLE.
  - Divide by zero: quotient = all ones (DIVU and DIV); remainder = op1.
  - Signed overflow (op1 = most negative, op2 = -1): quotient = op1, remainder = 0.
  - If DIV_FAST_SPECIAL, both special cases go IDLE->DONE, with valid_out in T+2.
  - Remainder sign follows the dividend; quotient truncates toward zero.
- Illegal funct7/funct3 combination:
  - Accepted, latency 1, valid_out=1, reg_we_out=0, reg_wdata_out=0.
- valid_out and reg_we_out:
  - Both are 0 in every cycle without a completion.
  - reg_wdata_out holds its last value and is not reset between ops.
- flush_in:
  - In any state, the next state is IDLE and no valid_out is produced for the aborted op.
  - A valid_in in the same cycle is not accepted.
  - If flush_in rises in the exact cycle valid_out=1, that result still stands; flush affects only later cycles.
- reset_in mid-divide behaves as flush, plus all outputs go to 0.
- No backpressure on output; the consumer always takes valid_out.

Decomposition:
- Shared package (defines): funct3 codes for ALU and M ops; funct7 codes BASE=0000000, ALT=0100000, MULDIV=0000001; WRITE_ENABLE/DISABLE; ZERO; state encodings IDLE/MUL/DIV/DONE.
- Sub-module exe_div_iter: XLEN-parametrised restoring divider with start/busy/done.
  - Inputs: unsigned magnitudes. Outputs: quotient and remainder.
  - The top level handles sign correction and special cases.

Test Plan:
- ADD 0x7FFFFFFF+1 -> 0x80000000 at T+1.
- SRA 0x80000010 by 4 -> 0xF8000001.
- Back-to-back ADD then SUB -> two valid_out pulses on consecutive cycles, ready_out=1 throughout.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000 and MULHU same operands -> 0xFFFFFFFE, each at T+2 with ready_out=0 for one cycle.
- DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF at T+34; ready_out low T+1..T+33.
- DIVU x/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, REM same -> 0, each at T+2 with DIV_FAST_SPECIAL=1.
- flush_in at T+10 of a DIV -> no valid_out, ready_out=1 at T+11, a new ADD accepted at T+11 completes at T+12.
- reset_in mid-MUL -> valid_out never pulses; all outputs 0 the next cycle.
